// File: rtl/core_dbg_pkg.sv
// core_dbg_pkg: register map, bit positions and FSM state encoding for the core debug controller
package core_dbg_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int IDX_ID = 0;
  localparam int IDX_CTRL = 1;
  localparam int IDX_STATUS = 2;
  localparam int IDX_REG_IDX = 3;
  localparam int IDX_REG_DATA = 4;
  localparam int IDX_REG_CMD = 5;
  localparam int IDX_BP_ADDR = 6;
  localparam int IDX_BP_CTRL = 7;
  localparam int IDX_PC = 8;
  localparam int CTRL_HALT = 0;
  localparam int CTRL_RESUME = 1;
  localparam int CTRL_STEP = 2;
  localparam int CTRL_CLR = 3;
  localparam int CMD_GO = 0;
  localparam int CMD_WRITE = 1;
  localparam int ST_HALTED = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_TMO = 2;
  localparam int ST_CMD = 3;
  localparam int ST_BP = 4;
  localparam int ST_STATE = 5;
  typedef enum logic [2:0] {
    S_RUNNING  = 3'd0,
    S_HALTING  = 3'd1,
    S_RESUMING = 3'd2,
    S_HALTED   = 3'd3,
    S_STEPPING = 3'd4,
    S_REG_ACC  = 3'd5
  } dbg_state_e;
endpackage

// File: rtl/core_dbg_timeout.sv
// core_dbg_timeout: loadable down-counter that pulses expire once it has run down while enabled
module core_dbg_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? W'(TIMEOUT - 1) : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  assign expire = en && cnt_q == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/core_dbg_ctrl.sv
// core_dbg_ctrl: debug register map plus halt/resume/step/GPR-access handshake FSM towards the core
module core_dbg_ctrl
  import core_dbg_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'hDC00_0001,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbg_req,
  input  logic              dbg_wr_rd,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              core_halt_req,
  output logic              core_resume_req,
  output logic              core_step,
  input  logic              core_halted,
  input  logic [DATA_W-1:0] core_pc,
  output logic              core_reg_req,
  output logic              core_reg_wr,
  output logic [4:0]        core_reg_idx,
  output logic [DATA_W-1:0] core_reg_wdata,
  input  logic [DATA_W-1:0] core_reg_rdata,
  input  logic              core_reg_ack,
  output logic              bp_en,
  output logic [DATA_W-1:0] bp_addr,
  input  logic              core_bp_hit
);
  dbg_state_e state_q, state_d;
  logic step_q, step_d, reg_wr_q, reg_wr_d, bp_en_q, bp_en_d, rvalid_q, rvalid_d;
  logic tmo_q, tmo_d, cmd_q, cmd_d, bph_q, bph_d;
  logic [4:0] reg_idx_q, reg_idx_d;
  logic [DATA_W-1:0] reg_data_q, reg_data_d, bp_addr_q, bp_addr_d, rdata_q, rdata_d, rd_mux;
  logic [7:0] status;
  logic wr_req, rd_req, wr_ctrl, wr_cmd, wr_idx, wr_data, wr_bpa, wr_bpc;
  logic halt_cmd, resume_cmd, step_cmd, go_cmd, clr, legal, busy, expire, tmo_set, cmd_set;
  assign wr_req = dbg_req && dbg_wr_rd;
  assign rd_req = dbg_req && !dbg_wr_rd;
  assign wr_ctrl = wr_req && dbg_addr == ADDR_W'(IDX_CTRL);
  assign wr_cmd = wr_req && dbg_addr == ADDR_W'(IDX_REG_CMD);
  assign wr_idx = wr_req && dbg_addr == ADDR_W'(IDX_REG_IDX);
  assign wr_data = wr_req && dbg_addr == ADDR_W'(IDX_REG_DATA);
  assign wr_bpa = wr_req && dbg_addr == ADDR_W'(IDX_BP_ADDR);
  assign wr_bpc = wr_req && dbg_addr == ADDR_W'(IDX_BP_CTRL);
  assign halt_cmd = wr_ctrl && dbg_wdata[CTRL_HALT];
  assign resume_cmd = wr_ctrl && !dbg_wdata[CTRL_HALT] && dbg_wdata[CTRL_RESUME];
  assign step_cmd = wr_ctrl && !dbg_wdata[CTRL_HALT] && !dbg_wdata[CTRL_RESUME] && dbg_wdata[CTRL_STEP];
  assign go_cmd = wr_cmd && dbg_wdata[CMD_GO];
  assign clr = wr_ctrl && dbg_wdata[CTRL_CLR];
  assign busy = state_q != S_RUNNING && state_q != S_HALTED;
  assign legal = (state_q == S_RUNNING && halt_cmd) || (state_q == S_HALTED && (resume_cmd || step_cmd || go_cmd));
  core_dbg_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk), .rst_n(rst_n), .load(state_d != state_q), .en(busy), .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    reg_wr_d = reg_wr_q;
    tmo_set = 1'b0;
    case (state_q)
      S_RUNNING: state_d = halt_cmd ? S_HALTING : core_halted ? S_HALTED : S_RUNNING;
      S_HALTING: state_d = core_halted ? S_HALTED : S_HALTING;
      S_HALTED: begin
        state_d = (resume_cmd || step_cmd) ? S_RESUMING : go_cmd ? S_REG_ACC : S_HALTED;
        step_d = (resume_cmd || step_cmd) ? step_cmd : step_q;
        reg_wr_d = go_cmd ? dbg_wdata[CMD_WRITE] : reg_wr_q;
      end
      S_RESUMING: state_d = core_halted ? S_RESUMING : step_q ? S_STEPPING : S_RUNNING;
      S_STEPPING: state_d = core_halted ? S_HALTED : S_STEPPING;
      S_REG_ACC: state_d = core_reg_ack ? S_HALTED : S_REG_ACC;
      default: state_d = S_RUNNING;
    endcase
    if (busy && expire && state_d == state_q) begin
      state_d = core_halted ? S_HALTED : S_RUNNING;
      tmo_set = 1'b1;
    end
    cmd_set = ((halt_cmd || resume_cmd || step_cmd || go_cmd) && !legal) || (wr_data && state_q == S_REG_ACC);
    tmo_d = tmo_set || (tmo_q && !clr);
    cmd_d = cmd_set || (cmd_q && !clr);
    bph_d = core_bp_hit || (bph_q && !clr);
    reg_idx_d = wr_idx ? dbg_wdata[4:0] : reg_idx_q;
    reg_data_d = (state_q == S_REG_ACC && core_reg_ack && !reg_wr_q) ? core_reg_rdata :
                 (wr_data && state_q != S_REG_ACC) ? dbg_wdata : reg_data_q;
    bp_addr_d = wr_bpa ? dbg_wdata : bp_addr_q;
    bp_en_d = wr_bpc ? dbg_wdata[0] : bp_en_q;
  end
  always_comb begin
    status = '0;
    status[ST_HALTED] = core_halted;
    status[ST_BUSY] = busy;
    status[ST_TMO] = tmo_q;
    status[ST_CMD] = cmd_q;
    status[ST_BP] = bph_q;
    status[ST_STATE +: 3] = state_q;
    rd_mux = '0;
    case (dbg_addr)
      ADDR_W'(IDX_ID): rd_mux = ID_VALUE;
      ADDR_W'(IDX_STATUS): rd_mux = DATA_W'(status);
      ADDR_W'(IDX_REG_IDX): rd_mux = DATA_W'(reg_idx_q);
      ADDR_W'(IDX_REG_DATA): rd_mux = reg_data_q;
      ADDR_W'(IDX_BP_ADDR): rd_mux = bp_addr_q;
      ADDR_W'(IDX_BP_CTRL): rd_mux = DATA_W'(bp_en_q);
      ADDR_W'(IDX_PC): rd_mux = core_pc;
      default: rd_mux = '0;
    endcase
    rdata_d = rd_req ? rd_mux : rdata_q;
    rvalid_d = rd_req;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUNNING;
      step_q <= 1'b0;
      reg_wr_q <= 1'b0;
      tmo_q <= 1'b0;
      cmd_q <= 1'b0;
      bph_q <= 1'b0;
      reg_idx_q <= '0;
      reg_data_q <= '0;
      bp_addr_q <= '0;
      bp_en_q <= 1'b0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      reg_wr_q <= reg_wr_d;
      tmo_q <= tmo_d;
      cmd_q <= cmd_d;
      bph_q <= bph_d;
      reg_idx_q <= reg_idx_d;
      reg_data_q <= reg_data_d;
      bp_addr_q <= bp_addr_d;
      bp_en_q <= bp_en_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign dbg_rdata = rdata_q;
  assign dbg_rvalid = rvalid_q;
  assign core_halt_req = state_q == S_HALTING;
  assign core_resume_req = state_q == S_RESUMING;
  assign core_step = state_q == S_RESUMING && step_q;
  assign core_reg_req = state_q == S_REG_ACC;
  assign core_reg_wr = state_q == S_REG_ACC && reg_wr_q;
  assign core_reg_idx = reg_idx_q;
  assign core_reg_wdata = reg_data_q;
  assign bp_en = bp_en_q;
  assign bp_addr = bp_addr_q;
endmodule

// File: tb/tb_core_dbg_ctrl.sv
// tb_core_dbg_ctrl: directed self-checking bench for core_dbg_ctrl with a hand-driven core model
module tb_core_dbg_ctrl;
  logic clk = 1'b0;
  logic rst_n, dbg_req, dbg_wr_rd, dbg_rvalid;
  logic [4:0] dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata, core_pc, core_reg_rdata, core_reg_wdata, bp_addr;
  logic core_halt_req, core_resume_req, core_step, core_halted;
  logic core_reg_req, core_reg_wr, core_reg_ack, bp_en, core_bp_hit;
  logic [4:0] core_reg_idx;
  int n_cmp = 0;
  int n_err = 0;
  int n;
  always #5 clk = ~clk;
  core_dbg_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .dbg_req(dbg_req), .dbg_wr_rd(dbg_wr_rd), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .core_halt_req(core_halt_req), .core_resume_req(core_resume_req), .core_step(core_step),
    .core_halted(core_halted), .core_pc(core_pc), .core_reg_req(core_reg_req),
    .core_reg_wr(core_reg_wr), .core_reg_idx(core_reg_idx), .core_reg_wdata(core_reg_wdata),
    .core_reg_rdata(core_reg_rdata), .core_reg_ack(core_reg_ack), .bp_en(bp_en),
    .bp_addr(bp_addr), .core_bp_hit(core_bp_hit)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    dbg_req = 1'b1; dbg_wr_rd = 1'b1; dbg_addr = a; dbg_wdata = d;
    tick();
    dbg_req = 1'b0; dbg_wr_rd = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    dbg_req = 1'b1; dbg_wr_rd = 1'b0; dbg_addr = a;
    tick();
    dbg_req = 1'b0;
    chk({tag, "_rvalid"}, 32'(dbg_rvalid), 32'd1);
    chk(tag, dbg_rdata, exp);
  endtask
  initial begin
    rst_n = 1'b0; dbg_req = 1'b0; dbg_wr_rd = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    core_halted = 1'b0; core_pc = 32'h1234_5678; core_reg_rdata = '0; core_reg_ack = 1'b0; core_bp_hit = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_halt_req", 32'(core_halt_req), 32'd0);
    chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    rd(5'd0, 32'hDC00_0001, "id");
    tick();
    chk("rvalid_drop", 32'(dbg_rvalid), 32'd0);
    chk("rdata_hold", dbg_rdata, 32'hDC00_0001);
    rd(5'd2, 32'h0, "status_reset");
    wr(5'd1, 32'h1);
    n = 1;
    chk("halt_req_on", 32'(core_halt_req), 32'd1);
    repeat (4) begin
      tick();
      n += int'(core_halt_req);
    end
    chk("halt_req_cycles", 32'(n), 32'd5);
    core_halted = 1'b1;
    tick();
    chk("halt_req_off", 32'(core_halt_req), 32'd0);
    rd(5'd2, 32'h61, "status_halted");
    wr(5'd3, 32'd7);
    wr(5'd4, 32'hCAFE);
    wr(5'd5, 32'h3);
    tick();
    chk("gpr_req", {core_reg_req, core_reg_wr, 30'(core_reg_idx)}, {1'b1, 1'b1, 30'd7});
    chk("gpr_wdata", core_reg_wdata, 32'hCAFE);
    core_reg_ack = 1'b1;
    tick();
    core_reg_ack = 1'b0;
    chk("gpr_req_off", 32'(core_reg_req), 32'd0);
    rd(5'd2, 32'h61, "status_after_gpr_wr");
    wr(5'd5, 32'h1);
    chk("gpr_rd_req", {core_reg_req, core_reg_wr}, 2'b10);
    core_reg_rdata = 32'hBEEF; core_reg_ack = 1'b1;
    tick();
    core_reg_ack = 1'b0;
    rd(5'd4, 32'hBEEF, "reg_data_rd");
    rd(5'd3, 32'd7, "reg_idx_rd");
    wr(5'd1, 32'h4);
    chk("step_req", {core_resume_req, core_step}, 2'b11);
    tick();
    chk("step_req_hold", {core_resume_req, core_step}, 2'b11);
    core_halted = 1'b0;
    tick();
    chk("step_req_off", {core_resume_req, core_step}, 2'b00);
    rd(5'd2, 32'h82, "status_stepping");
    core_halted = 1'b1;
    tick();
    rd(5'd8, 32'h1234_5678, "pc");
    rd(5'd2, 32'h61, "status_step_done");
    wr(5'd1, 32'h2);
    chk("resume_req", {core_resume_req, core_step}, 2'b10);
    core_halted = 1'b0;
    tick();
    chk("resume_req_off", 32'(core_resume_req), 32'd0);
    rd(5'd2, 32'h0, "status_running");
    wr(5'd1, 32'h1);
    n = 0;
    while (core_halt_req && n < 40) begin
      n++;
      tick();
    end
    chk("timeout_cycles", 32'(n), 32'd16);
    rd(5'd2, 32'h04, "status_timeout");
    wr(5'd1, 32'h8);
    rd(5'd2, 32'h0, "status_cleared");
    wr(5'd5, 32'h1);
    chk("go_running_noreq", 32'(core_reg_req), 32'd0);
    rd(5'd2, 32'h08, "status_cmd_err");
    core_bp_hit = 1'b1;
    tick();
    core_bp_hit = 1'b0;
    rd(5'd2, 32'h18, "status_bp_hit");
    rd(5'd15, 32'h0, "unmapped");
    wr(5'd6, 32'h100);
    wr(5'd7, 32'h1);
    chk("bp_out", {bp_en, bp_addr[30:0]}, {1'b1, 31'h100});
    rd(5'd6, 32'h100, "bp_addr_rd");
    wr(5'd1, 32'hB);
    chk("multi_halt_req", {core_halt_req, core_resume_req}, 2'b10);
    rd(5'd2, 32'h22, "status_multi_clr");
    rst_n = 1'b0;
    tick();
    chk("rst_mid_halt", {core_halt_req, bp_en}, 2'b00);
    rst_n = 1'b1;
    rd(5'd2, 32'h0, "status_post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/core_dbg_ctrl.md
Name: core_dbg_ctrl

Overview:
- Sits directly downstream of the core debug APB slave and consumes its one-cycle request pulse (req, wr_rd, addr, wdata).
- Implements the core debug register map and the halt / resume / single-step / GPR-access state machine that drives the CPU core's debug handshake.
- Returns read data to the APB slave with fixed latency.

Parameters:
ADDR_W, 5, debug register address width (matches APB slave addr width)
DATA_W, 32, debug data width
ID_VALUE, 32'hDC00_0001, constant returned by ID register
TIMEOUT, 1024, cycles to wait for any core handshake before abort

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
dbg_req  in  1  one-cycle request pulse from APB slave
dbg_wr_rd  in  1  1=write, 0=read
dbg_addr  in  ADDR_W  register index
dbg_wdata  in  DATA_W  write data
dbg_rdata  out  DATA_W  read data
dbg_rvalid  out  1  one-cycle pulse, read data valid
core_halt_req  out  1  level, request core halt
core_resume_req  out  1  level, request core resume
core_step  out  1  level, valid with core_resume_req: execute one instruction then halt
core_halted  in  1  core is halted
core_pc  in  DATA_W  current PC (valid when halted)
core_reg_req  out  1  level, GPR access request
core_reg_wr  out  1  1=GPR write
core_reg_idx  out  5  GPR index
core_reg_wdata  out  DATA_W  GPR write data
core_reg_rdata  in  DATA_W  GPR read data, valid with ack
core_reg_ack  in  1  one-cycle GPR access done
bp_en  out  1  breakpoint enable
bp_addr  out  DATA_W  breakpoint address
core_bp_hit  in  1  pulse: core halted on breakpoint

Behaviour:
- Clocking/reset: one clock; synchronous active-low reset on clk/rst_n.
- Reset values: all outputs 0; state RUNNING; REG_IDX/REG_DATA/BP regs/sticky bits 0.
- Register map (index = dbg_addr):
  - 0 ID RO
  - 1 CTRL WO: b0 HALT, b1 RESUME, b2 STEP, b3 CLR_STICKY; self-clearing
  - 2 STATUS RO: b0 core_halted, b1 busy (state not RUNNING/HALTED), b2 timeout_err, b3 cmd_err, b4 bp_hit, b7:5 state
  - 3 REG_IDX RW [4:0]
  - 4 REG_DATA RW
  - 5 REG_CMD WO: b0 GO, b1 WRITE
  - 6 BP_ADDR RW
  - 7 BP_CTRL RW b0 = bp_en
  - 8 PC RO = core_pc
  - Others: read 0, write ignored; no error flag.
- Reads:
  - dbg_rdata registered; dbg_rvalid pulses exactly 1 cycle after a read dbg_req, regardless of FSM state.
  - dbg_rdata holds its value until the next read.
- FSM states: RUNNING, HALTING, HALTED, RESUMING, STEPPING, REG_ACC.
  - RUNNING + HALT -> HALTING: core_halt_req=1 until core_halted=1, then -> HALTED (halt_req drops same edge).
  - HALTED + RESUME -> RESUMING: core_resume_req=1 until core_halted=0, then -> RUNNING.
  - HALTED + STEP -> RESUMING with core_step=1. On core_halted=0 -> STEPPING (resume_req/step drop). On core_halted=1 -> HALTED.
  - HALTED + REG_CMD.GO -> REG_ACC: core_reg_req=1, core_reg_wr=WRITE, idx=REG_IDX, wdata=REG_DATA until core_reg_ack. On a read ack, REG_DATA <= core_reg_rdata. Then -> HALTED.
- Illegal or concurrent commands:
  - Any CTRL/REG_CMD command that is illegal in the current state sets cmd_err and is ignored (e.g. HALT while HALTED, GO while RUNNING, any command while busy).
  - Multiple CTRL bits in one write: priority HALT > RESUME > STEP; CLR_STICKY is always honoured alongside.
- Timeout:
  - A counter is cleared on entry to HALTING/RESUMING/STEPPING/REG_ACC.
  - Reaching TIMEOUT-1 without the handshake sets timeout_err, drops all core requests, and goes to RUNNING if core_halted=0, else HALTED.
- core_bp_hit sets sticky bp_hit. If the core halts by itself while RUNNING (core_halted rises), go directly to HALTED.
- Sticky bits clear only by CLR_STICKY or reset. CLR_STICKY and a same-cycle set: set wins.
- Register writes to REG_IDX/REG_DATA/BP_* are accepted in any state. A REG_DATA write during REG_ACC is ignored and sets cmd_err.
- Reset mid-operation drops all core request lines on the next edge; no completion is reported.

Decomposition:
- Package core_dbg_pkg: register index localparams, CTRL/REG_CMD/STATUS bit positions, state enum (3-bit), DATA_W default.
- Sub-module core_dbg_timeout: loadable down-counter with clear, enable and expire pulse.
- Everything else lives in one module.

Test Plan:
- Reset then read idx 0 and idx 2 -> rvalid 1 cycle after req; rdata=32'hDC00_0001, then 0.
- Write CTRL=1; core raises core_halted after 5 cycles -> core_halt_req high 5 cycles then 0; STATUS=0x61 (state HALTED=3, halted=1).
- Halted; REG_IDX=7, REG_DATA=0xCAFE, REG_CMD=3 -> core_reg_req/wr=1, idx=7, wdata=0xCAFE until ack. Then REG_CMD=1 with rdata 0xBEEF -> REG_DATA reads 0xBEEF.
- Halted; CTRL=4 -> resume_req+step until halted falls, STEPPING, halted rises -> HALTED. Reading PC returns core_pc.
- CTRL=1 with core never halting, TIMEOUT=16 -> halt_req drops after 16 cycles, STATUS b2=1, state RUNNING. CTRL=8 -> b2=0.
- REG_CMD=1 while RUNNING -> no core_reg_req, cmd_err=1. Reset asserted mid-HALTING -> core_halt_req 0 next edge.
